// File: rtl/rtc_calendar.sv
// Real-time clock/calendar (sec..year) with prescaler, Gregorian leap rule, field set mode; RTC_ALARM_EN adds an hh:mm alarm.
// Latency: registers update on the tick edge, BCD outputs follow combinationally, sec_tick/alarm registered with the update.
// Backpressure: none; set_inc is consumed on every edge it is high, no flow control on outputs.
module rtc_calendar #(
    parameter int TICK_DIV = 50000000,
    parameter int RST_YEAR = 2024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic [2:0]  set_field,
    input  logic        set_inc,
`ifdef RTC_ALARM_EN
    input  logic [4:0]  alarm_hour,
    input  logic [5:0]  alarm_min,
    input  logic        alarm_arm,
    output logic        alarm,
`endif
    output logic        sec_tick,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  min_bcd,
    output logic [7:0]  hour_bcd,
    output logic [7:0]  day_bcd,
    output logic [7:0]  month_bcd,
    output logic [15:0] year_bcd
);
    // TICK_DIV=1 would give a zero-width prescaler; keep one bit that simply stays 0.
    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [5:0]    sec, min, sec_n, min_n;
    logic [4:0]    hour, day, hour_n, day_n;
    logic [3:0]    month, month_n;
    logic [13:0]   year, year_n;
    logic [PW-1:0] presc, presc_n;
    logic          tick_n;
    logic [4:0]    dim_cur, dim_new;
`ifdef RTC_ALARM_EN
    logic          alarm_n;
`endif

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
        logic leap;
        leap = ((y[1:0] == 2'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
            4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
            default:                 days_in_month = 5'd31;
        endcase
    endfunction

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        bcd2 = {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [15:0] bcd4(input logic [13:0] v);
        bcd4 = {4'(v / 14'd1000), 4'((v / 14'd100) % 14'd10),
                4'((v / 14'd10) % 14'd10), 4'(v % 14'd10)};
    endfunction

    // Next-state: set-mode field edits (with day clamp) or run-mode prescaler and full carry cascade.
    always_comb begin
        sec_n   = sec;
        min_n   = min;
        hour_n  = hour;
        day_n   = day;
        month_n = month;
        year_n  = year;
        presc_n = presc;
        tick_n  = 1'b0;
        dim_cur = days_in_month(month, year);
        dim_new = dim_cur;
        if (mode) begin
            presc_n = '0;
            if (set_inc) begin
                case (set_field)
                    3'd0: sec_n  = (sec  == 6'd59) ? 6'd0 : sec  + 6'd1;
                    3'd1: min_n  = (min  == 6'd59) ? 6'd0 : min  + 6'd1;
                    3'd2: hour_n = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                    3'd3: day_n  = (day >= dim_cur) ? 5'd1 : day + 5'd1;
                    3'd4: begin
                        month_n = (month == 4'd12) ? 4'd1 : month + 4'd1;
                        dim_new = days_in_month(month_n, year);
                        if (day > dim_new) day_n = dim_new;
                    end
                    3'd5: begin
                        year_n  = (year == 14'd9999) ? 14'd0 : year + 14'd1;
                        dim_new = days_in_month(month, year_n);
                        if (day > dim_new) day_n = dim_new;
                    end
                    default: ;
                endcase
            end
        end else if (presc == PRESC_MAX) begin
            presc_n = '0;
            tick_n  = 1'b1;
            if (sec == 6'd59) begin
                sec_n = 6'd0;
                if (min == 6'd59) begin
                    min_n = 6'd0;
                    if (hour == 5'd23) begin
                        hour_n = 5'd0;
                        if (day >= dim_cur) begin
                            day_n = 5'd1;
                            if (month == 4'd12) begin
                                month_n = 4'd1;
                                year_n  = (year == 14'd9999) ? 14'd0 : year + 14'd1;
                            end else begin
                                month_n = month + 4'd1;
                            end
                        end else begin
                            day_n = day + 5'd1;
                        end
                    end else begin
                        hour_n = hour + 5'd1;
                    end
                end else begin
                    min_n = min + 6'd1;
                end
            end else begin
                sec_n = sec + 6'd1;
            end
        end else begin
            presc_n = presc + PW'(1);
        end
`ifdef RTC_ALARM_EN
        // Match against the values the tick lands on, so the pulse marks hh:mm:00 itself.
        alarm_n = tick_n && alarm_arm && (hour_n == alarm_hour) && (min_n == alarm_min) && (sec_n == 6'd0);
`endif
    end

    // State registers with synchronous reset to 00:00:00 01/01/RST_YEAR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec      <= 6'd0;
            min      <= 6'd0;
            hour     <= 5'd0;
            day      <= 5'd1;
            month    <= 4'd1;
            year     <= 14'(RST_YEAR);
            presc    <= '0;
            sec_tick <= 1'b0;
`ifdef RTC_ALARM_EN
            alarm    <= 1'b0;
`endif
        end else begin
            sec      <= sec_n;
            min      <= min_n;
            hour     <= hour_n;
            day      <= day_n;
            month    <= month_n;
            year     <= year_n;
            presc    <= presc_n;
            sec_tick <= tick_n;
`ifdef RTC_ALARM_EN
            alarm    <= alarm_n;
`endif
        end
    end

    // Display conversion is combinational so digits move in the same cycle as the registers.
    always_comb begin
        sec_bcd   = bcd2(7'(sec));
        min_bcd   = bcd2(7'(min));
        hour_bcd  = bcd2(7'(hour));
        day_bcd   = bcd2(7'(day));
        month_bcd = bcd2(7'(month));
        year_bcd  = bcd4(year);
    end
endmodule

// File: tb/tb_rtc_calendar.sv
module tb_rtc_calendar;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  set_field = 3'd0;
    logic        set_inc = 1'b0;
    logic        sec_tick;
    logic [7:0]  sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd;
    logic [15:0] year_bcd;
`ifdef RTC_ALARM_EN
    logic [4:0]  alarm_hour = 5'd7;
    logic [5:0]  alarm_min = 6'd30;
    logic        alarm_arm = 1'b0;
    logic        alarm;
`endif

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rtc_calendar #(.TICK_DIV(TD), .RST_YEAR(2024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .set_field (set_field),
        .set_inc   (set_inc),
`ifdef RTC_ALARM_EN
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .alarm_arm (alarm_arm),
        .alarm     (alarm),
`endif
        .sec_tick  (sec_tick),
        .sec_bcd   (sec_bcd),
        .min_bcd   (min_bcd),
        .hour_bcd  (hour_bcd),
        .day_bcd   (day_bcd),
        .month_bcd (month_bcd),
        .year_bcd  (year_bcd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic inc_field(input logic [2:0] f, input int n);
        set_field = f;
        if (n > 0) begin
            set_inc = 1'b1;
            repeat (n) step();
            set_inc = 1'b0;
        end
    endtask

    // Reset, then reach the requested time from the known reset state by set-mode increments.
    task automatic set_time(input int h, input int m, input int s, input int d, input int mo, input int y);
        mode = 1'b1;
        do_reset();
        inc_field(3'd5, (y + 10000 - 2024) % 10000);
        inc_field(3'd4, mo - 1);
        inc_field(3'd3, d - 1);
        inc_field(3'd2, h);
        inc_field(3'd1, m);
        inc_field(3'd0, s);
    endtask

    task automatic wait_tick(output int gap);
        gap = 0;
        do begin
            step();
            gap++;
        end while (!sec_tick && gap < 20);
    endtask

    // Leave set mode and expect the tick on exactly the TD-th run-mode edge.
    task automatic tick_from_set(input string name);
        int gap;
        mode = 1'b0;
        wait_tick(gap);
        n_checks++;
        if (gap !== TD) $display("FAIL %s_tick_gap got %0d cycles exp %0d", name, gap, TD);
        else n_pass++;
        mode = 1'b1;
    endtask

    task automatic test_reset();
        mode = 1'b0;
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000)
            $display("FAIL reset_time got %h exp 000000", {hour_bcd, min_bcd, sec_bcd});
        else n_pass++;
        n_checks++;
        if ({day_bcd, month_bcd, year_bcd} !== 32'h0101_2024)
            $display("FAIL reset_date got %h exp 01012024", {day_bcd, month_bcd, year_bcd});
        else n_pass++;
        n_checks++;
        if (sec_tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", sec_tick);
        else n_pass++;
    endtask

    task automatic test_run();
        int gap;
        rst_n = 1'b1;
        for (int p = 1; p <= 60; p++) begin
            wait_tick(gap);
            n_checks++;
            if (gap !== TD) $display("FAIL tick_gap pulse %0d got %0d exp %0d", p, gap, TD);
            else n_pass++;
            if (p == 1) begin
                n_checks++;
                if ({min_bcd, sec_bcd} !== 16'h0001) $display("FAIL first_sec got %h exp 0001", {min_bcd, sec_bcd});
                else n_pass++;
            end
            if (p == 59) begin
                n_checks++;
                if ({min_bcd, sec_bcd} !== 16'h0059) $display("FAIL sec59 got %h exp 0059", {min_bcd, sec_bcd});
                else n_pass++;
            end
            if (p == 60) begin
                n_checks++;
                if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000100)
                    $display("FAIL min_carry got %h exp 000100", {hour_bcd, min_bcd, sec_bcd});
                else n_pass++;
            end
        end
    endtask

    task automatic test_year_rollover();
        set_time(23, 59, 59, 31, 12, 2024);
        tick_from_set("new_year");
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd} !== 56'h000000_0101_2025)
            $display("FAIL new_year got %h exp 00000001012025", {hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd});
        else n_pass++;
    endtask

    task automatic test_leap();
        int          yrs [4] = '{2023, 2024, 2100, 2000};
        logic [31:0] exp [4] = '{32'h0103_2023, 32'h2902_2024, 32'h0103_2100, 32'h2902_2000};
        for (int i = 0; i < 4; i++) begin
            set_time(23, 59, 59, 28, 2, yrs[i]);
            tick_from_set("leap");
            n_checks++;
            if ({day_bcd, month_bcd, year_bcd} !== exp[i])
                $display("FAIL leap_%0d got %h exp %h", yrs[i], {day_bcd, month_bcd, year_bcd}, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_year_wrap();
        set_time(23, 59, 59, 31, 12, 9999);
        tick_from_set("y9999");
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd} !== 56'h000000_0101_0000)
            $display("FAIL year_wrap got %h exp 00000001010000", {hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd});
        else n_pass++;
    endtask

    task automatic test_set_mode();
        int gap;
        set_time(0, 0, 59, 31, 1, 2023);
        n_checks++;
        if ({day_bcd, month_bcd, year_bcd} !== 32'h3101_2023)
            $display("FAIL set_load got %h exp 31012023", {day_bcd, month_bcd, year_bcd});
        else n_pass++;
        inc_field(3'd0, 1);
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000)
            $display("FAIL set_sec_wrap got %h exp 000000", {hour_bcd, min_bcd, sec_bcd});
        else n_pass++;
        inc_field(3'd4, 1);
        n_checks++;
        if ({day_bcd, month_bcd, year_bcd} !== 32'h2802_2023)
            $display("FAIL month_clamp got %h exp 28022023", {day_bcd, month_bcd, year_bcd});
        else n_pass++;
        inc_field(3'd7, 1);
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd} !== 56'h000000_2802_2023)
            $display("FAIL field7 got %h exp 00000028022023", {hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd});
        else n_pass++;
        mode = 1'b0;
        inc_field(3'd4, 1);
        n_checks++;
        if ({sec_tick, hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd} !== 57'h0_000000_2802_2023)
            $display("FAIL run_inc got %h exp 00000028022023", {sec_tick, hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd});
        else n_pass++;
        step();
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({sec_tick, hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd} !== 57'h0_000000_0101_2024)
            $display("FAIL mid_reset got %h exp 00000001012024", {sec_tick, hour_bcd, min_bcd, sec_bcd, day_bcd, month_bcd, year_bcd});
        else n_pass++;
        rst_n = 1'b1;
        wait_tick(gap);
        n_checks++;
        if (gap !== TD) $display("FAIL post_reset_gap got %0d exp %0d", gap, TD);
        else n_pass++;
        // Leap-day clamp on a year step: 29/02/2024 -> 28/02/2025.
        set_time(0, 0, 0, 29, 2, 2024);
        inc_field(3'd5, 1);
        n_checks++;
        if ({day_bcd, month_bcd, year_bcd} !== 32'h2802_2025)
            $display("FAIL year_clamp got %h exp 28022025", {day_bcd, month_bcd, year_bcd});
        else n_pass++;
    endtask

    task automatic test_mode_switch();
        mode = 1'b0;
        do_reset();
        repeat (TD - 1) step();
        mode = 1'b1;
        step();
        n_checks++;
        if ({sec_tick, sec_bcd} !== 9'h000) $display("FAIL set_wins got %h exp 000", {sec_tick, sec_bcd});
        else n_pass++;
        tick_from_set("resume");
        n_checks++;
        if (sec_bcd !== 8'h01) $display("FAIL resume_sec got %h exp 01", sec_bcd);
        else n_pass++;
    endtask

`ifdef RTC_ALARM_EN
    task automatic run_alarm(input logic arm, input int exp_cnt, input string name);
        int cnt = 0;
        int bad = 0;
        alarm_arm = arm;
        set_time(7, 29, 58, 1, 1, 2024);
        mode = 1'b0;
        repeat (4 * TD) begin
            step();
            if (alarm === 1'b1) begin
                cnt++;
                if (!(sec_tick === 1'b1 && {hour_bcd, min_bcd, sec_bcd} === 24'h073000)) bad++;
            end
        end
        n_checks++;
        if (cnt !== exp_cnt || bad !== 0)
            $display("FAIL %s got %0d pulses (%0d misplaced) exp %0d", name, cnt, bad, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_alarm();
        run_alarm(1'b1, 1, "alarm_armed");
        run_alarm(1'b0, 0, "alarm_disarmed");
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_year_rollover();
        test_leap();
        test_year_wrap();
        test_set_mode();
        test_mode_switch();
`ifdef RTC_ALARM_EN
        test_alarm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
